// File: rtl/pipe_pkg.sv
// Shared types for the memory stage: scoreboard entry, writeback bundle, saturating helper.
package pipe_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int REG_W_DEFAULT = 5;

  typedef struct packed {
    logic                     valid;
    logic [REG_W_DEFAULT-1:0] regD;
  } sb_entry_t;

  typedef struct packed {
    logic                     regwrite;
    logic                     jal;
    logic [REG_W_DEFAULT-1:0] regD;
    logic [XLEN_DEFAULT-1:0]  target;
    logic [XLEN_DEFAULT-1:0]  regdata;
  } wb_bundle_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mshr_scoreboard.sv
// Tag-indexed miss scoreboard: allocate/free, full/empty, lowest-free encoder,
// two-port RAW match and WAW match (register 0 never matches).
module mshr_scoreboard
  import pipe_pkg::*;
#(
  parameter  int MSHR_DEPTH = 4,
  parameter  int REG_W      = REG_W_DEFAULT,
  localparam int TAG_W      = $clog2(MSHR_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_i,
  input  logic [TAG_W-1:0] alloc_tag_i,
  input  logic [REG_W-1:0] alloc_reg_i,
  input  logic             free_i,
  input  logic [TAG_W-1:0] free_tag_i,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic [REG_W-1:0] rd_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [TAG_W-1:0] free_idx_o,
  output logic             raw_o,
  output logic             waw_o,
  output logic             free_hit_o,
  output logic [REG_W-1:0] free_reg_o
);

  sb_entry_t             ent_q [MSHR_DEPTH];
  logic [MSHR_DEPTH-1:0] valid_vec, raw_vec, waw_vec;

  generate
    for (genvar gi = 0; gi < MSHR_DEPTH; gi++) begin : g_match
      assign valid_vec[gi] = ent_q[gi].valid;
      assign raw_vec[gi]   = ent_q[gi].valid &&
                             (((rs1_i != '0) && (ent_q[gi].regD == rs1_i)) ||
                              ((rs2_i != '0) && (ent_q[gi].regD == rs2_i)));
      assign waw_vec[gi]   = ent_q[gi].valid && (rd_i != '0) && (ent_q[gi].regD == rd_i);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MSHR_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        if (free_i && (free_tag_i == TAG_W'(i)))
          ent_q[i].valid <= 1'b0;
        else if (alloc_i && (alloc_tag_i == TAG_W'(i)))
          ent_q[i] <= '{valid: 1'b1, regD: alloc_reg_i};
      end
    end
  end

  // Scan high to low so the lowest free index wins.
  always_comb begin
    free_idx_o = '0;
    for (int i = MSHR_DEPTH - 1; i >= 0; i--)
      if (!valid_vec[i]) free_idx_o = TAG_W'(i);
  end

  assign full_o     = &valid_vec;
  assign empty_o    = ~|valid_vec;
  assign raw_o      = |raw_vec;
  assign waw_o      = |waw_vec;
  assign free_hit_o = valid_vec[free_tag_i];
  assign free_reg_o = ent_q[free_tag_i].regD;

endmodule

// File: rtl/mem_stage_tagged.sv
// Memory stage with out-of-order load-miss scoreboard, stalls, forwarding and registered WB.
// Optional MEM_STAGE_STATS_EN adds saturating miss / dependency-stall / full-stall counters.
module mem_stage_tagged
  import pipe_pkg::*;
#(
  parameter  int XLEN       = XLEN_DEFAULT,
  parameter  int MSHR_DEPTH = 4,
  parameter  int REG_W      = REG_W_DEFAULT,
  localparam int TAG_W      = $clog2(MSHR_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_in,
  input  logic             regwrite,
  input  logic             load,
  input  logic             store,
  input  logic             jal,
  input  logic             jalr,
  input  logic             branch_cond,
  input  logic [XLEN-1:0]  target,
  input  logic [XLEN-1:0]  result,
  input  logic [XLEN-1:0]  store_data,
  input  logic [REG_W-1:0] regD,
  input  logic [REG_W-1:0] reg1_ex,
  input  logic [REG_W-1:0] reg2_ex,
  output logic             fwd_we,
  output logic [REG_W-1:0] fwd_regD,
  output logic [XLEN-1:0]  fwd_val,
  output logic             branch_flush,
  output logic [XLEN-1:0]  b_target,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_lw,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [TAG_W-1:0] mem_tag,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             hit_ack,
  input  logic             miss_accept,
  input  logic             mem_busy,
  input  logic             done_valid,
  input  logic [TAG_W-1:0] done_tag,
  input  logic [XLEN-1:0]  done_data,
  output logic             regwriteF,
  output logic             jalF,
  output logic [REG_W-1:0] regDF,
  output logic [XLEN-1:0]  targetF,
  output logic [XLEN-1:0]  regdataF
`ifdef MEM_STAGE_STATS_EN
  ,
  output logic [31:0]      stat_miss_cnt,
  output logic [31:0]      stat_dep_stall_cnt,
  output logic [31:0]      stat_full_stall_cnt
`endif
);

  logic             sb_alloc, sb_free, sb_full, sb_empty, sb_raw, sb_waw, sb_done_hit;
  logic [TAG_W-1:0] sb_free_idx;
  logic [REG_W-1:0] sb_done_reg;
  logic             dep_stall, full_stall, miss_evt;
  wb_bundle_t       wb_q, wb_d;

  mshr_scoreboard #(.MSHR_DEPTH(MSHR_DEPTH), .REG_W(REG_W)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .alloc_i    (sb_alloc),
    .alloc_tag_i(sb_free_idx),
    .alloc_reg_i(regD),
    .free_i     (sb_free),
    .free_tag_i (done_tag),
    .rs1_i      (reg1_ex),
    .rs2_i      (reg2_ex),
    .rd_i       (regD),
    .full_o     (sb_full),
    .empty_o    (sb_empty),
    .free_idx_o (sb_free_idx),
    .raw_o      (sb_raw),
    .waw_o      (sb_waw),
    .free_hit_o (sb_done_hit),
    .free_reg_o (sb_done_reg)
  );

  always_comb begin
    fwd_we       = 1'b0;
    fwd_regD     = '0;
    fwd_val      = '0;
    branch_flush = 1'b0;
    b_target     = '0;
    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_lw       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_tag      = '0;
    sb_alloc     = 1'b0;
    sb_free      = 1'b0;
    dep_stall    = 1'b0;
    full_stall   = 1'b0;
    miss_evt     = 1'b0;
    wb_d         = '{regwrite: regwrite, jal: jal | jalr, regD: regD,
                     target: target, regdata: result};
    if (!rst) begin
      wb_d = '0;
    end else if (flush_in) begin
      wb_d = '0;
    end else if (done_valid && sb_done_hit) begin
      // Completion owns the WB slot this cycle, so the current instruction waits.
      stall        = 1'b1;
      sb_free      = 1'b1;
      wb_d         = '0;
      wb_d.regwrite = 1'b1;
      wb_d.regD    = sb_done_reg;
      wb_d.regdata = done_data;
    end else if (sb_raw || (regwrite && sb_waw)) begin
      stall     = 1'b1;
      dep_stall = 1'b1;
      wb_d      = '0;
    end else if (load && sb_full) begin
      stall      = 1'b1;
      full_stall = 1'b1;
      wb_d       = '0;
    end else if (load || store) begin
      mem_req   = 1'b1;
      mem_lw    = load;
      mem_addr  = result;
      mem_wdata = store_data;
      mem_tag   = sb_free_idx;
      if (mem_busy) begin
        stall = 1'b1;
        wb_d  = '0;
      end else if (load && hit_ack) begin
        wb_d.regdata = mem_rdata;
        fwd_we       = 1'b1;
        fwd_regD     = regD;
        fwd_val      = mem_rdata;
      end else if (load && miss_accept) begin
        sb_alloc = 1'b1;
        miss_evt = 1'b1;
        wb_d     = '0;
        stall    = (regD != '0) && ((reg1_ex == regD) || (reg2_ex == regD));
      end
    end else begin
      if (regwrite) begin
        fwd_we   = 1'b1;
        fwd_regD = regD;
        fwd_val  = result;
      end
      // Control flow waits until no miss is outstanding.
      if ((jal || jalr || branch_cond) && !sb_empty) begin
        stall = 1'b1;
        wb_d  = '0;
      end else begin
        branch_flush = branch_cond;
        b_target     = target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wb_q <= '0;
    else      wb_q <= wb_d;
  end

  assign regwriteF = wb_q.regwrite;
  assign jalF      = wb_q.jal;
  assign regDF     = wb_q.regD;
  assign targetF   = wb_q.target;
  assign regdataF  = wb_q.regdata;

`ifdef MEM_STAGE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_miss_cnt       <= '0;
      stat_dep_stall_cnt  <= '0;
      stat_full_stall_cnt <= '0;
    end else begin
      if (miss_evt)   stat_miss_cnt       <= sat_inc(stat_miss_cnt);
      if (dep_stall)  stat_dep_stall_cnt  <= sat_inc(stat_dep_stall_cnt);
      if (full_stall) stat_full_stall_cnt <= sat_inc(stat_full_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_tagged.sv
// Scoreboard bench for mem_stage_tagged: expected WB bundles are queued when a cycle is driven
// and compared after the clock edge that registers them.
module tb_mem_stage_tagged;

  logic        clk, rst, flush_in, regwrite, load, store, jal, jalr, branch_cond;
  logic [31:0] target, result, store_data, mem_rdata, done_data;
  logic [4:0]  regD, reg1_ex, reg2_ex;
  logic        hit_ack, miss_accept, mem_busy, done_valid;
  logic [1:0]  done_tag;
  logic        fwd_we, branch_flush, stall, mem_req, mem_lw, regwriteF, jalF;
  logic [4:0]  fwd_regD, regDF;
  logic [31:0] fwd_val, b_target, mem_addr, mem_wdata, targetF, regdataF;
  logic [1:0]  mem_tag;
`ifdef MEM_STAGE_STATS_EN
  logic [31:0] stat_miss_cnt, stat_dep_stall_cnt, stat_full_stall_cnt;
`endif

  mem_stage_tagged dut (
    .clk(clk), .rst(rst), .flush_in(flush_in), .regwrite(regwrite), .load(load),
    .store(store), .jal(jal), .jalr(jalr), .branch_cond(branch_cond), .target(target),
    .result(result), .store_data(store_data), .regD(regD), .reg1_ex(reg1_ex),
    .reg2_ex(reg2_ex), .fwd_we(fwd_we), .fwd_regD(fwd_regD), .fwd_val(fwd_val),
    .branch_flush(branch_flush), .b_target(b_target), .stall(stall), .mem_req(mem_req),
    .mem_lw(mem_lw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_tag(mem_tag),
    .mem_rdata(mem_rdata), .hit_ack(hit_ack), .miss_accept(miss_accept),
    .mem_busy(mem_busy), .done_valid(done_valid), .done_tag(done_tag),
    .done_data(done_data), .regwriteF(regwriteF), .jalF(jalF), .regDF(regDF),
    .targetF(targetF), .regdataF(regdataF)
`ifdef MEM_STAGE_STATS_EN
    , .stat_miss_cnt(stat_miss_cnt), .stat_dep_stall_cnt(stat_dep_stall_cnt),
    .stat_full_stall_cnt(stat_full_stall_cnt)
`endif
  );

  typedef struct packed {
    logic        rw;
    logic        jal;
    logic [4:0]  rd;
    logic [31:0] tgt;
    logic [31:0] data;
  } wb_t;

  localparam wb_t BUB = '0;

  wb_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic wb_t W(input logic rw, input logic j, input logic [4:0] rd,
                            input logic [31:0] tgt, input logic [31:0] data);
    return '{rw: rw, jal: j, rd: rd, tgt: tgt, data: data};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush_in = 0; regwrite = 0; load = 0; store = 0; jal = 0; jalr = 0; branch_cond = 0;
    target = 0; result = 0; store_data = 0; regD = 0; reg1_ex = 0; reg2_ex = 0;
    mem_rdata = 0; hit_ack = 0; miss_accept = 0; mem_busy = 0;
    done_valid = 0; done_tag = 0; done_data = 0;
  endtask

  // One pipeline cycle: combinational checks at negedge, queued WB check after posedge.
  task automatic cyc(input string tag, input logic e_stall, input logic e_req,
                     input logic [1:0] e_tag, input logic e_bf, input wb_t e_wb);
    wb_t w;
    exp_q.push_back(e_wb);
    @(negedge clk);
    check({tag, ".stall"}, stall, e_stall);
    check({tag, ".req"}, mem_req, e_req);
    if (e_req) check({tag, ".tag"}, mem_tag, e_tag);
    check({tag, ".bflush"}, branch_flush, e_bf);
    if (e_bf) check({tag, ".btgt"}, b_target, target);
    @(posedge clk); #1;
    w = exp_q.pop_front();
    check({tag, ".regwriteF"}, regwriteF, w.rw);
    check({tag, ".jalF"}, jalF, w.jal);
    check({tag, ".regDF"}, regDF, w.rd);
    check({tag, ".targetF"}, targetF, w.tgt);
    check({tag, ".regdataF"}, regdataF, w.data);
    $display("[%0t] %s stall=%b req=%b tag=%0d wb=%b/x%0d/%h", $time, tag, e_stall, e_req,
             e_tag, regwriteF, regDF, regdataF);
  endtask

  task automatic miss(input string tag, input logic [4:0] rd, input logic [1:0] t);
    idle(); load = 1; regwrite = 1; regD = rd; result = 32'h1000 + rd; miss_accept = 1;
    cyc(tag, 0, 1, t, 0, BUB);
  endtask

  task automatic done(input string tag, input logic [1:0] t, input logic [4:0] rd,
                      input logic [31:0] d);
    done_valid = 1; done_tag = t; done_data = d;
    cyc(tag, 1, 0, 0, 0, W(1, 0, rd, 0, d));
    done_valid = 0;
  endtask

  initial begin
    logic [1:0]  dtag [4];
    logic [4:0]  dreg [4];
    idle();
    rst = 0;
    load = 1; regwrite = 1; regD = 5;
    repeat (2) @(posedge clk);
    #1;
    check("rst.mem_req", mem_req, 0);
    check("rst.stall", stall, 0);
    check("rst.regwriteF", regwriteF, 0);
    check("rst.regDF", regDF, 0);
    check("rst.regdataF", regdataF, 0);
    idle();
    @(negedge clk) rst = 1;
    @(posedge clk); #1;

    // Miss, RAW stall held, completion, then release.
    idle(); load = 1; regwrite = 1; regD = 5; result = 32'h100; miss_accept = 1;
    #2;
    check("s1.addr", mem_addr, 32'h100);
    check("s1.lw", mem_lw, 1);
    cyc("s1_miss", 0, 1, 0, 0, BUB);
    idle(); regwrite = 1; regD = 9; result = 32'h11; reg1_ex = 5;
    cyc("s1_raw0", 1, 0, 0, 0, BUB);
    cyc("s1_raw1", 1, 0, 0, 0, BUB);
    done("s1_done", 0, 5, 32'hCAFE);
    #2;
    check("s1.fwd_we", fwd_we, 1);
    check("s1.fwd_regD", fwd_regD, 9);
    check("s1.fwd_val", fwd_val, 32'h11);
    cyc("s1_add", 0, 0, 0, 0, W(1, 0, 9, 0, 32'h11));

    // Fill all four entries, full stall, free entry 2, fifth load takes tag 2.
    for (int i = 0; i < 4; i++) miss("s2_miss", 5'(i + 1), 2'(i));
    idle(); load = 1; regwrite = 1; regD = 10; result = 32'h300;
    cyc("s2_full0", 1, 0, 0, 0, BUB);
    cyc("s2_full1", 1, 0, 0, 0, BUB);
    done("s2_free", 2, 3, 32'h33);
    miss_accept = 1;
    cyc("s2_fifth", 0, 1, 2, 0, BUB);
    dtag = '{2'd0, 2'd1, 2'd3, 2'd2};
    dreg = '{5'd1, 5'd2, 5'd4, 5'd10};
    idle();
    for (int i = 0; i < 4; i++) done("s2_drain", dtag[i], dreg[i], 32'hA0 + i);

    // Out-of-order completion, then a branch proves the scoreboard is empty.
    miss("s3_miss6", 6, 0);
    miss("s3_miss7", 7, 1);
    idle();
    done("s3_done7", 1, 7, 32'h77);
    done("s3_done6", 0, 6, 32'h66);
    branch_cond = 1; target = 32'h500;
    cyc("s3_br", 0, 0, 0, 1, W(0, 0, 0, 32'h500, 0));

    // WAW on x8.
    miss("s4_miss8", 8, 0);
    idle(); regwrite = 1; regD = 8; result = 32'h5;
    cyc("s4_waw0", 1, 0, 0, 0, BUB);
    cyc("s4_waw1", 1, 0, 0, 0, BUB);
    done("s4_done8", 0, 8, 32'h88);
    cyc("s4_add", 0, 0, 0, 0, W(1, 0, 8, 0, 32'h5));

    // Branch held behind a pending miss.
    miss("s5_miss12", 12, 0);
    idle(); branch_cond = 1; target = 32'h400;
    cyc("s5_brwait", 1, 0, 0, 0, BUB);
    done("s5_done12", 0, 12, 32'hC);
    cyc("s5_br", 0, 0, 0, 1, W(0, 0, 0, 32'h400, 0));
    idle(); jal = 1; regwrite = 1; regD = 1; target = 32'h600; result = 32'h44;
    cyc("s5_jal", 0, 0, 0, 0, W(1, 1, 1, 32'h600, 32'h44));

    // Hit, store, busy, flush, stale completion tag.
    idle(); load = 1; regwrite = 1; regD = 3; result = 32'h40; hit_ack = 1; mem_rdata = 32'hABCD;
    #2;
    check("s6.hit_fwd_val", fwd_val, 32'hABCD);
    cyc("s6_hit", 0, 1, 0, 0, W(1, 0, 3, 0, 32'hABCD));
    idle(); store = 1; result = 32'h80; store_data = 32'h55; hit_ack = 1;
    #2;
    check("s6.wdata", mem_wdata, 32'h55);
    check("s6.st_lw", mem_lw, 0);
    cyc("s6_store", 0, 1, 0, 0, W(0, 0, 0, 0, 32'h80));
    idle(); load = 1; regwrite = 1; regD = 11; result = 32'h90; mem_busy = 1;
    cyc("s6_busy", 1, 1, 0, 0, BUB);
    idle(); flush_in = 1; regwrite = 1; regD = 4; result = 32'h9;
    cyc("s6_flush", 0, 0, 0, 0, BUB);
    idle(); done_valid = 1; done_tag = 3; done_data = 32'hDEAD; regwrite = 1; regD = 4; result = 32'h44;
    cyc("s6_stale", 0, 0, 0, 0, W(1, 0, 4, 0, 32'h44));

    // Asynchronous reset while a miss is outstanding.
    miss("s7_miss5", 5, 0);
    idle(); load = 1; regwrite = 1; regD = 3; result = 32'h44; hit_ack = 1; mem_rdata = 32'hBEEF;
    cyc("s7_hit", 0, 1, 1, 0, W(1, 0, 3, 0, 32'hBEEF));
    #2 rst = 0;
    #1;
    check("s7.rst_req", mem_req, 0);
    check("s7.rst_regwriteF", regwriteF, 0);
    check("s7.rst_regDF", regDF, 0);
    check("s7.rst_regdataF", regdataF, 0);
    idle();
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    miss("s7_after", 5, 0);
    idle();
    done("s7_done", 0, 5, 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
